// File: rtl/tdp_ram_clr.sv
// True dual-port synchronous RAM with a post-reset clear sweep, selectable
// read-during-write ordering and a registered same-address collision flag.
module tdp_ram_clr #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 5,
  parameter int                 RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dia,
  output logic [DATA_W-1:0] doa,
  input  logic              enb,
  input  logic              web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dib,
  output logic [DATA_W-1:0] dob,
  output logic              busy,
  output logic              collision
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

  // Handshake: none. A port acts on every edge where enP=1 and busy=0;
  // doP is valid after that edge and holds while enP=0.

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   clr_addr, clr_addr_nxt;
  logic [DATA_W-1:0] ram [DEPTH];
  logic              ready, wr_a, wr_b;
  logic [DATA_W-1:0] new_a, new_b;

  assign ready = (state == ST_READY);
  assign busy  = (state == ST_CLEAR);
  assign wr_a  = ready & ena & wea;
  assign wr_b  = ready & enb & web;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    if (state == ST_CLEAR) begin
      clr_addr_nxt = clr_addr + 1'b1;
      if (clr_addr == CLR_LAST) state_nxt = ST_READY;
    end
  end

  // Word each port would see after this edge's writes; port A wins a
  // same-address double write.
  always_comb begin
    new_a = ram[addra];
    if (wr_a)                        new_a = dia;
    else if (wr_b && addrb == addra) new_a = dib;
    new_b = ram[addrb];
    if (wr_a && addra == addrb)      new_b = dia;
    else if (wr_b)                   new_b = dib;
  end

  // Memory is left alone on reset edges; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_CLEAR) begin
        ram[clr_addr[ADDR_W-1:0]] <= CLR_VAL;
      end else begin
        if (wr_b) ram[addrb] <= dib;
        if (wr_a) ram[addra] <= dia;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      doa       <= '0;
      dob       <= '0;
      collision <= 1'b0;
    end else begin
      if (ready && ena) doa <= (RDW_MODE != 0) ? new_a : ram[addra];
      if (ready && enb) dob <= (RDW_MODE != 0) ? new_b : ram[addrb];
      collision <= ready & ena & enb & (addra == addrb) & (wea | web);
    end
  end

endmodule

// File: tb/tb_tdp_ram_clr.sv
// Directed bench for tdp_ram_clr: read-first and write-first instances share
// stimulus; a negedge monitor pops expected read data and collision values.
`timescale 1ns/1ps
module tb_tdp_ram_clr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena, wea, enb, web;
  logic [4:0] addra, addrb;
  logic [7:0] dia, dib;
  logic [7:0] doa0, dob0, doa1, dob1;
  logic       busy0, busy1, coll0, coll1;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa0[$], qb0[$], qa1[$], qb1[$];
  logic       qc[$];
  logic       chk_a = 1'b0, chk_b = 1'b0, chk_c = 1'b0;
  logic       pend_a = 1'b0, pend_b = 1'b0, pend_c = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  tdp_ram_clr #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(0), .CLR_VAL(8'hA5)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa0),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob0),
    .busy(busy0), .collision(coll0)
  );

  tdp_ram_clr #(.DATA_W(8), .ADDR_W(5), .RDW_MODE(1), .CLR_VAL(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia), .doa(doa1),
    .enb(enb), .web(web), .addrb(addrb), .dib(dib), .dob(dob1),
    .busy(busy1), .collision(coll1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h req=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: outputs of the edge just passed
  always @(posedge clk) begin
    pend_a <= chk_a;
    pend_b <= chk_b;
    pend_c <= chk_c;
  end

  always @(negedge clk) begin
    if (pend_a) begin
      if (qa0.size() == 0 || qa1.size() == 0) chk("qa_empty", 1, 0);
      else begin
        chk("doa_rf", doa0, qa0.pop_front());
        chk("doa_wf", doa1, qa1.pop_front());
      end
    end
    if (pend_b) begin
      if (qb0.size() == 0 || qb1.size() == 0) chk("qb_empty", 1, 0);
      else begin
        chk("dob_rf", dob0, qb0.pop_front());
        chk("dob_wf", dob1, qb1.pop_front());
      end
    end
    if (pend_c) begin
      if (qc.size() == 0) chk("qc_empty", 1, 0);
      else begin
        logic e;
        e = qc.pop_front();
        chk("coll_rf", coll0, e);
        chk("coll_wf", coll1, e);
      end
    end
  end

  // driver: one READY-cycle operation, called at a negedge
  task automatic op(input logic a_en, input logic a_we, input logic [4:0] a_ad, input logic [7:0] a_d,
                    input logic b_en, input logic b_we, input logic [4:0] b_ad, input logic [7:0] b_d,
                    input logic [7:0] ea0, input logic [7:0] ea1,
                    input logic [7:0] eb0, input logic [7:0] eb1, input logic ec);
    ena = a_en; wea = a_we; addra = a_ad; dia = a_d;
    enb = b_en; web = b_we; addrb = b_ad; dib = b_d;
    if (a_en) begin qa0.push_back(ea0); qa1.push_back(ea1); end
    if (b_en) begin qb0.push_back(eb0); qb1.push_back(eb1); end
    qc.push_back(ec);
    chk_a = a_en; chk_b = b_en; chk_c = 1'b1;
    @(negedge clk);
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    chk_a = 1'b0; chk_b = 1'b0; chk_c = 1'b0;
  endtask

  task automatic idle();
    op(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // counts edges until busy falls, bounded
  task automatic wait_sweep(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (n == 16) begin
        chk("busy_doa_hold", doa0, 8'h00);
        chk("busy_mid", busy0, 1'b1);
      end
      if (!busy0) break;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ena = 0; wea = 0; enb = 0; web = 0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 1'b1);
    chk("rst_doa", doa0, 8'h00);
    chk("rst_dob", dob1, 8'h00);
    chk("rst_coll", coll0, 1'b0);

    // T1 + T6: release reset while port A tries to write 2
    rst_n = 1'b1;
    ena = 1'b1; wea = 1'b1; addra = 5'd2; dia = 8'hFF;
    wait_sweep(n);
    ena = 1'b0; wea = 1'b0;
    chk("sweep_len", n, 32);
    chk("busy_wf_done", busy1, 1'b0);
    chk("busy_doa_rf", doa0, 8'h00);
    chk("busy_doa_wf", doa1, 8'h00);

    op(1, 0, 5'd0,  8'h00, 1, 0, 5'd17, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    op(1, 0, 5'd31, 8'h00, 1, 0, 5'd2,  8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);

    // T2
    op(1, 1, 5'd7, 8'h3C, 0, 0, 5'd0, 8'h00, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0);
    op(0, 0, 5'd0, 8'h00, 1, 0, 5'd7, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 1'b0);
    idle();

    // T3
    op(1, 1, 5'd9, 8'h11, 0, 0, 5'd0, 8'h00, 8'hA5, 8'h11, 8'h00, 8'h00, 1'b0);
    op(1, 1, 5'd9, 8'h22, 1, 0, 5'd9, 8'h00, 8'h11, 8'h22, 8'h11, 8'h22, 1'b1);
    idle();
    op(1, 0, 5'd9, 8'h00, 0, 0, 5'd0, 8'h00, 8'h22, 8'h22, 8'h00, 8'h00, 1'b0);

    // T4
    op(1, 1, 5'd4, 8'hAA, 1, 1, 5'd4, 8'h55, 8'hA5, 8'hAA, 8'hA5, 8'hAA, 1'b1);
    idle();
    op(0, 0, 5'd0, 8'h00, 1, 0, 5'd4, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 1'b0);
    op(1, 0, 5'd4, 8'h00, 1, 0, 5'd4, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b0);

    // independent addresses
    op(1, 1, 5'd10, 8'h01, 1, 1, 5'd11, 8'h02, 8'hA5, 8'h01, 8'hA5, 8'h02, 1'b0);
    op(1, 0, 5'd11, 8'h00, 1, 0, 5'd10, 8'h00, 8'h02, 8'h02, 8'h01, 8'h01, 1'b0);

    // T5: mid-sweep reset restarts from 0
    op(1, 1, 5'd30, 8'h77, 0, 0, 5'd0, 8'h00, 8'hA5, 8'h77, 8'h00, 8'h00, 1'b0);
    op(1, 0, 5'd30, 8'h00, 0, 0, 5'd0, 8'h00, 8'h77, 8'h77, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_busy_at12", busy0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_doa", doa0, 8'h00);
    rst_n = 1'b1;
    wait_sweep(n);
    chk("t5_sweep_len", n, 32);
    op(1, 0, 5'd30, 8'h00, 1, 0, 5'd9, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    idle();

    repeat (2) @(negedge clk);
    chk("q_drained", qa0.size() + qb0.size() + qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
